lpf_decimator: RTL and testbench

- Downstream stage of lp_filter: consumes the 24-bit unsigned y_out stream, block-averages N = 2^DEC_LOG2 samples and rescales by right shift with unsigned saturation to OUT_W bits.
- Buffers results in a small FIFO with a valid/ready output handshake for a slower consumer (logger, DAC, UART packer).
- Sticky flags report saturation and FIFO overflow.

---
 rtl/lpf_decimator.sv | 139 +++++++++++++
 tb/tb_lpf_decimator.sv | 188 ++++++++++++++++++
 2 files changed

// File: rtl/lpf_decimator.sv
// Block-average decimator for the lp_filter output stream with a small valid/ready output FIFO.
// Optional peak-hold register enabled by defining LPF_PEAK_HOLD_EN.
module lpf_decimator #(
  parameter int unsigned IN_W       = 24,
  parameter int unsigned OUT_W      = 12,
  parameter int unsigned DEC_LOG2   = 3,
  parameter int unsigned SHIFT      = 4,
  parameter int unsigned FIFO_DEPTH = 4
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic [IN_W-1:0]               y_in,
  input  logic                          sample_en,
  output logic [OUT_W-1:0]              out_data,
  output logic                          out_valid,
  input  logic                          out_ready,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_level,
  output logic                          sat_flag,
  output logic                          ovf_flag,
  input  logic                          clr_flags,
  output logic [OUT_W-1:0]              peak
);

  localparam int unsigned ACC_W = IN_W + DEC_LOG2;
  localparam int unsigned CNT_W = DEC_LOG2;
  localparam int unsigned PTR_W = $clog2(FIFO_DEPTH);
  localparam int unsigned LVL_W = PTR_W + 1;
  localparam logic [OUT_W-1:0] RES_MAX = '1;

  logic [ACC_W-1:0] acc, acc_n;
  logic [CNT_W-1:0] cnt, cnt_n;
  logic [OUT_W-1:0] mem [FIFO_DEPTH];
  logic [OUT_W-1:0] mem_n [FIFO_DEPTH];
  logic [PTR_W-1:0] rd_ptr, rd_ptr_n, wr_ptr, wr_ptr_n;
  logic [LVL_W-1:0] level_n;
  logic [OUT_W-1:0] out_data_n;
  logic             sat_n, ovf_n;

  logic [ACC_W-1:0] sum, avg, scaled;
  logic [OUT_W-1:0] result;
  logic             clip, blk_done, pop, push, drop, full;

  // Block arithmetic: truncating average, extra shift, unsigned saturation.
  always_comb begin
    sum    = acc + ACC_W'(y_in);
    avg    = sum >> DEC_LOG2;
    scaled = avg >> SHIFT;
    clip   = scaled > ACC_W'(RES_MAX);
    result = clip ? RES_MAX : scaled[OUT_W-1:0];
  end

  // Next-state logic for accumulator, FIFO and flags.
  always_comb begin
    acc_n      = acc;
    cnt_n      = cnt;
    mem_n      = mem;
    rd_ptr_n   = rd_ptr;
    wr_ptr_n   = wr_ptr;
    level_n    = fifo_level;
    out_data_n = '0;

    blk_done = sample_en && (&cnt);
    full     = fifo_level == LVL_W'(FIFO_DEPTH);
    pop      = out_valid && out_ready;
    push     = blk_done && (!full || pop);
    drop     = blk_done && full && !pop;

    if (sample_en) begin
      if (blk_done) begin
        acc_n = '0;
        cnt_n = '0;
      end else begin
        acc_n = sum;
        cnt_n = cnt + CNT_W'(1);
      end
    end

    // A push into a full FIFO that is also popping reuses the slot being vacated.
    if (push) begin
      mem_n[wr_ptr] = result;
      wr_ptr_n      = wr_ptr + PTR_W'(1);
    end
    if (pop) rd_ptr_n = rd_ptr + PTR_W'(1);
    level_n = fifo_level + LVL_W'(push) - LVL_W'(pop);
    if (level_n != '0) out_data_n = mem_n[rd_ptr_n];

    sat_n = (sat_flag && !clr_flags) || (blk_done && clip);
    ovf_n = (ovf_flag && !clr_flags) || drop;
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      acc        <= '0;
      cnt        <= '0;
      rd_ptr     <= '0;
      wr_ptr     <= '0;
      fifo_level <= '0;
      out_data   <= '0;
      out_valid  <= 1'b0;
      sat_flag   <= 1'b0;
      ovf_flag   <= 1'b0;
      for (int i = 0; i < int'(FIFO_DEPTH); i++) mem[i] <= '0;
    end else begin
      acc        <= acc_n;
      cnt        <= cnt_n;
      mem        <= mem_n;
      rd_ptr     <= rd_ptr_n;
      wr_ptr     <= wr_ptr_n;
      fifo_level <= level_n;
      out_data   <= out_data_n;
      out_valid  <= level_n != '0;
      sat_flag   <= sat_n;
      ovf_flag   <= ovf_n;
    end
  end

`ifdef LPF_PEAK_HOLD_EN
  logic [OUT_W-1:0] peak_n;

  // Peak tracks accepted pushes only; a push in the clearing cycle restarts from that result.
  always_comb begin
    peak_n = peak;
    if (push) begin
      if (clr_flags)         peak_n = result;
      else if (result > peak) peak_n = result;
    end else if (clr_flags) begin
      peak_n = '0;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) peak <= '0;
    else      peak <= peak_n;
  end
`else
  assign peak = '0;
`endif

endmodule

// File: tb/tb_lpf_decimator.sv
// Randomized and directed bench for lpf_decimator against a queue-based reference model.
module tb_lpf_decimator;

  localparam int unsigned IN_W       = 24;
  localparam int unsigned OUT_W      = 12;
  localparam int unsigned DEC_LOG2   = 3;
  localparam int unsigned SHIFT      = 4;
  localparam int unsigned FIFO_DEPTH = 4;
  localparam int          N          = 1 << DEC_LOG2;
  localparam longint      RES_MAX    = (64'd1 << OUT_W) - 1;

  logic                        clk = 1'b0;
  logic                        rst = 1'b0;
  logic [IN_W-1:0]             y_in = '0;
  logic                        sample_en = 1'b0;
  logic [OUT_W-1:0]            out_data;
  logic                        out_valid;
  logic                        out_ready = 1'b0;
  logic [$clog2(FIFO_DEPTH):0] fifo_level;
  logic                        sat_flag;
  logic                        ovf_flag;
  logic                        clr_flags = 1'b0;
  logic [OUT_W-1:0]            peak;

  lpf_decimator #(
    .IN_W(IN_W), .OUT_W(OUT_W), .DEC_LOG2(DEC_LOG2), .SHIFT(SHIFT), .FIFO_DEPTH(FIFO_DEPTH)
  ) dut (
    .clk(clk), .rst(rst), .y_in(y_in), .sample_en(sample_en),
    .out_data(out_data), .out_valid(out_valid), .out_ready(out_ready),
    .fifo_level(fifo_level), .sat_flag(sat_flag), .ovf_flag(ovf_flag),
    .clr_flags(clr_flags), .peak(peak)
  );

  always #5 clk = ~clk;

  int n_vec = 0;
  int n_err = 0;

  // Reference model state: samples of the open block, FIFO contents, flags.
  longint blk[$];
  longint fifo[$];
  bit     m_sat, m_ovf;
  longint m_peak;

  task automatic check(input string tag, input longint got, input longint exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", tag, got, exp, $time);
    end
  endtask

  task automatic model_edge();
    longint s, res;
    bit     done, clip, pop, pushed;
    if (!rst) begin
      blk.delete(); fifo.delete();
      m_sat = 0; m_ovf = 0; m_peak = 0;
      return;
    end
    pop = (fifo.size() > 0) && out_ready;
    done = 0; clip = 0; res = 0; pushed = 0;
    if (sample_en) begin
      blk.push_back(longint'(y_in));
      if (blk.size() == N) begin
        s = 0;
        foreach (blk[i]) s += blk[i];
        res = s / N / (64'd1 << SHIFT);
        clip = res > RES_MAX;
        if (clip) res = RES_MAX;
        done = 1;
        blk.delete();
      end
    end
    if (pop) void'(fifo.pop_front());
    if (done) begin
      if (fifo.size() < FIFO_DEPTH) begin
        fifo.push_back(res);
        pushed = 1;
      end
    end
    m_sat = (m_sat && !clr_flags) || (done && clip);
    m_ovf = (m_ovf && !clr_flags) || (done && !pushed);
    if (pushed) m_peak = clr_flags ? res : ((res > m_peak) ? res : m_peak);
    else if (clr_flags) m_peak = 0;
  endtask

  task automatic compare_all();
    check("out_valid", longint'(out_valid), longint'(fifo.size() > 0));
    check("out_data", longint'(out_data), (fifo.size() > 0) ? fifo[0] : 0);
    check("fifo_level", longint'(fifo_level), longint'(fifo.size()));
    check("sat_flag", longint'(sat_flag), longint'(m_sat));
    check("ovf_flag", longint'(ovf_flag), longint'(m_ovf));
`ifdef LPF_PEAK_HOLD_EN
    check("peak", longint'(peak), m_peak);
`else
    check("peak", longint'(peak), 0);
`endif
  endtask

  task automatic step(input logic [IN_W-1:0] y, input logic en, input logic rdy,
                      input logic clr, input logic r);
    y_in = y; sample_en = en; out_ready = rdy; clr_flags = clr; rst = r;
    @(posedge clk);
    model_edge();
    #1;
    compare_all();
  endtask

  initial begin
    int v;
    logic [IN_W-1:0] ry;

    // Constant stream: 160 averages to 10.
    for (int i = 0; i < 3; i++) step('0, 1'b0, 1'b1, 1'b0, 1'b0);
    check("rst_level", longint'(fifo_level), 0);
    check("rst_data", longint'(out_data), 0);
    for (int i = 0; i < 4 * N; i++) begin
      step(IN_W'(160), 1'b1, 1'b1, 1'b0, 1'b1);
      if (i % N == N - 1) check("const_out", longint'(out_data), 10);
    end

    // Saturation, clear, and re-assertion.
    for (int i = 0; i < 2 * N; i++) step(IN_W'(1048576), 1'b1, 1'b1, 1'b0, 1'b1);
    check("sat_out", longint'(out_data), 4095);
    check("sat_set", longint'(sat_flag), 1);
    step('0, 1'b0, 1'b1, 1'b1, 1'b1);
    check("sat_clr", longint'(sat_flag), 0);
    for (int i = 0; i < N; i++) step(IN_W'(1048576), 1'b1, 1'b1, 1'b0, 1'b1);
    check("sat_reset", longint'(sat_flag), 1);

    // Backpressure: five blocks into a four-deep FIFO, then drain.
    step('0, 1'b0, 1'b1, 1'b1, 1'b1);
    for (int b = 1; b <= 5; b++)
      for (int i = 0; i < N; i++) step(IN_W'(16 * b), 1'b1, 1'b0, 1'b0, 1'b1);
    check("bp_level", longint'(fifo_level), 4);
    check("bp_ovf", longint'(ovf_flag), 1);
    for (int k = 1; k <= 4; k++) begin
      check("bp_order", longint'(out_data), k);
      step('0, 1'b0, 1'b1, 1'b0, 1'b1);
    end
    check("bp_empty", longint'(out_valid), 0);

    // Reset mid-block discards the partial sum.
    for (int i = 0; i < 5; i++) step(IN_W'(999), 1'b1, 1'b1, 1'b0, 1'b1);
    step(IN_W'(999), 1'b1, 1'b1, 1'b0, 1'b0);
    for (int i = 0; i < N; i++) step(IN_W'(320), 1'b1, 1'b0, 1'b0, 1'b1);
    check("rstmid_level", longint'(fifo_level), 1);
    check("rstmid_out", longint'(out_data), 20);
    step('0, 1'b0, 1'b1, 1'b0, 1'b1);

    // sample_en gaps with garbage on idle cycles.
    for (int i = 0; i < 2 * N; i++)
      step((i % 2 == 0) ? IN_W'(480) : IN_W'(4000000), (i % 2 == 0), 1'b0, 1'b0, 1'b1);
    check("gap_out", longint'(out_data), 30);
    check("gap_level", longint'(fifo_level), 1);

    // Full FIFO with push and pop on the same edge.
    step('0, 1'b0, 1'b1, 1'b1, 1'b1);
    for (int b = 0; b < 4; b++)
      for (int i = 0; i < N; i++)
        step(IN_W'(16 * ((b == 1) ? 25 : (b == 2) ? 12 : 7)), 1'b1, 1'b0, 1'b0, 1'b1);
    for (int i = 0; i < N; i++) step(IN_W'(16 * 25), 1'b1, (i == N - 1), 1'b0, 1'b1);
    check("pp_level", longint'(fifo_level), 4);
    check("pp_ovf", longint'(ovf_flag), 0);
`ifdef LPF_PEAK_HOLD_EN
    check("pp_peak", longint'(peak), 25);
`endif
    for (int i = 0; i < 6; i++) step('0, 1'b0, 1'b1, 1'b0, 1'b1);

    // Randomized traffic.
    for (int i = 0; i < 4000; i++) begin
      v = int'($urandom_range(0, 3));
      case (v)
        0:       ry = IN_W'($urandom_range(0, 4095));
        1:       ry = IN_W'($urandom_range(0, 1 << 20));
        2:       ry = IN_W'($urandom);
        default: ry = IN_W'((1 << IN_W) - 1 - int'($urandom_range(0, 255)));
      endcase
      step(ry, ($urandom_range(0, 3) != 0), ($urandom_range(0, 2) == 0),
           ($urandom_range(0, 40) == 0), ($urandom_range(0, 400) != 0));
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
